// File: rtl/decode_feed_arbiter_pkg.sv
// Shared constants for the decode feed arbiter: default sizing, field widths
// and the arbiter FSM state encoding.
package decode_feed_arbiter_pkg;

    localparam int NUM_REQ      = 4;
    localparam int HALF_TIMEOUT = 15;
    localparam int WFID_W       = 6;
    localparam int INSTR_W      = 32;
    localparam int PC_W         = 32;

    localparam int STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_CHECK = 2'd1;
    localparam logic [STATE_W-1:0] ST_HALF  = 2'd2;

    // Index width that stays legal even for a single requester.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/decode_feed_arbiter_rr_picker.sv
// Round-robin one-hot picker: first valid requester at or after ptr_i, wrapping.
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = decode_feed_arbiter_pkg::idxWidth(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);
    import decode_feed_arbiter_pkg::*;

    always_comb begin
        int  cand;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = int'(ptr_i) + off;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_valid_i[cand]) begin
                found         = 1'b1;
                idx_o         = IDX_W'(cand);
                grant_o[cand] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/decode_feed_arbiter.sv
// Feeds instruction dwords from the wavepool requesters into decode, fetching
// the second dword of long instructions from the same requester on demand.
module decode_feed_arbiter #(
    parameter int NUM_REQ      = decode_feed_arbiter_pkg::NUM_REQ,
    parameter int HALF_TIMEOUT = decode_feed_arbiter_pkg::HALF_TIMEOUT
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [NUM_REQ-1:0]                                  req_valid,
    input  logic [decode_feed_arbiter_pkg::INSTR_W*NUM_REQ-1:0] req_instr,
    input  logic [decode_feed_arbiter_pkg::PC_W*NUM_REQ-1:0]    req_pc,
    input  logic [decode_feed_arbiter_pkg::WFID_W*NUM_REQ-1:0]  req_wfid,
    input  logic                                                issue_stall,
    input  logic                                                half_rqd,
    input  logic [decode_feed_arbiter_pkg::WFID_W-1:0]          half_wfid,
    output logic [NUM_REQ-1:0]                                  grant,
    output logic                                                wave_instr_valid,
    output logic [decode_feed_arbiter_pkg::INSTR_W-1:0]         wave_instr,
    output logic [decode_feed_arbiter_pkg::PC_W-1:0]            wave_instr_pc,
    output logic [decode_feed_arbiter_pkg::WFID_W-1:0]          wave_wfid,
    output logic                                                err_half_mismatch,
    output logic                                                err_half_timeout
);
    import decode_feed_arbiter_pkg::*;

    localparam int IDX_W = idxWidth(NUM_REQ);
    localparam int CNT_W = $clog2(HALF_TIMEOUT + 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   latchIdx_q, latchIdx_d;
    logic [WFID_W-1:0]  latchWfid_q, latchWfid_d;
    logic [CNT_W-1:0]   halfCnt_q, halfCnt_d;
    logic               waveValid_q;
    logic [INSTR_W-1:0] waveInstr_q;
    logic [PC_W-1:0]    wavePc_q;
    logic [WFID_W-1:0]  waveWfid_q;
    logic               errMismatch_q, errMismatch_d;
    logic               errTimeout_q, errTimeout_d;

    logic [NUM_REQ-1:0] rrGrant;
    logic [IDX_W-1:0]   rrIdx;
    logic               rrAny;
    logic [IDX_W-1:0]   gntIdx;
    logic               gntAny;

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_valid_i (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (rrGrant),
        .idx_o       (rrIdx),
        .any_o       (rrAny)
    );

    // The second-dword fetch bypasses issue_stall and leaves the pointer alone
    // so long instructions do not perturb round-robin fairness.
    always_comb begin
        grant         = '0;
        gntIdx        = latchIdx_q;
        gntAny        = 1'b0;
        state_d       = state_q;
        ptr_d         = ptr_q;
        latchIdx_d    = latchIdx_q;
        latchWfid_d   = latchWfid_q;
        halfCnt_d     = halfCnt_q;
        errMismatch_d = 1'b0;
        errTimeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!issue_stall && rrAny) begin
                    grant       = rrGrant;
                    gntIdx      = rrIdx;
                    gntAny      = 1'b1;
                    ptr_d       = (rrIdx == IDX_W'(NUM_REQ - 1)) ? '0 : rrIdx + 1'b1;
                    latchIdx_d  = rrIdx;
                    latchWfid_d = req_wfid[rrIdx*WFID_W +: WFID_W];
                    state_d     = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!half_rqd) begin
                    state_d = ST_IDLE;
                end else if (half_wfid == latchWfid_q) begin
                    state_d   = ST_HALF;
                    halfCnt_d = '0;
                end else begin
                    errMismatch_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_HALF: begin
                if (req_valid[latchIdx_q]) begin
                    grant[latchIdx_q] = 1'b1;
                    gntAny            = 1'b1;
                    state_d           = ST_IDLE;
                end else if (halfCnt_q == CNT_W'(HALF_TIMEOUT - 1)) begin
                    errTimeout_d = 1'b1;
                    state_d      = ST_IDLE;
                end else begin
                    halfCnt_d = halfCnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rst) grant = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            latchIdx_q    <= '0;
            latchWfid_q   <= '0;
            halfCnt_q     <= '0;
            waveValid_q   <= 1'b0;
            waveInstr_q   <= '0;
            wavePc_q      <= '0;
            waveWfid_q    <= '0;
            errMismatch_q <= 1'b0;
            errTimeout_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            latchIdx_q    <= latchIdx_d;
            latchWfid_q   <= latchWfid_d;
            halfCnt_q     <= halfCnt_d;
            waveValid_q   <= gntAny;
            errMismatch_q <= errMismatch_d;
            errTimeout_q  <= errTimeout_d;
            if (gntAny) begin
                waveInstr_q <= req_instr[gntIdx*INSTR_W +: INSTR_W];
                wavePc_q    <= req_pc[gntIdx*PC_W +: PC_W];
                waveWfid_q  <= req_wfid[gntIdx*WFID_W +: WFID_W];
            end
        end
    end

    assign wave_instr_valid  = waveValid_q;
    assign wave_instr        = waveInstr_q;
    assign wave_instr_pc     = wavePc_q;
    assign wave_wfid         = waveWfid_q;
    assign err_half_mismatch = errMismatch_q;
    assign err_half_timeout  = errTimeout_q;

endmodule

// File: tb/tb_decode_feed_arbiter.sv
// Directed bench for decode_feed_arbiter with a cycle-level reference model.
module tb_decode_feed_arbiter;

    localparam int N  = 4;
    localparam int TO = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [32*N-1:0] req_instr;
    logic [32*N-1:0] req_pc;
    logic [6*N-1:0] req_wfid;
    logic           issue_stall;
    logic           half_rqd;
    logic [5:0]     half_wfid;
    logic [N-1:0]   grant;
    logic           wave_instr_valid;
    logic [31:0]    wave_instr;
    logic [31:0]    wave_instr_pc;
    logic [5:0]     wave_wfid;
    logic           err_half_mismatch;
    logic           err_half_timeout;

    int checks   = 0;
    int failures = 0;

    decode_feed_arbiter #(.NUM_REQ(N), .HALF_TIMEOUT(TO)) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_instr         (req_instr),
        .req_pc            (req_pc),
        .req_wfid          (req_wfid),
        .issue_stall       (issue_stall),
        .half_rqd          (half_rqd),
        .half_wfid         (half_wfid),
        .grant             (grant),
        .wave_instr_valid  (wave_instr_valid),
        .wave_instr        (wave_instr),
        .wave_instr_pc     (wave_instr_pc),
        .wave_wfid         (wave_wfid),
        .err_half_mismatch (err_half_mismatch),
        .err_half_timeout  (err_half_timeout)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic waitCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] valid, input logic stall,
                                 input logic hrqd, input logic [5:0] hwfid);
        req_valid   = valid;
        issue_stall = stall;
        half_rqd    = hrqd;
        half_wfid   = hwfid;
    endtask

    task automatic setPayload(input int i, input logic [31:0] instr,
                              input logic [31:0] pc, input logic [5:0] wfid);
        req_instr[32*i +: 32] = instr;
        req_pc[32*i +: 32]    = pc;
        req_wfid[6*i +: 6]    = wfid;
    endtask

    // Reference model: a free/check/half phase view of the feed, evaluated
    // mid-cycle from the stable inputs; it predicts this cycle's grant and the
    // registered outputs seen next cycle.
    int          mPhase = 0;
    int          mPtr = 0, mIdx = 0, mWait = 0;
    logic [5:0]  mWfid = '0;
    logic        eValid = 1'b0, eErrM = 1'b0, eErrT = 1'b0;
    logic [31:0] eInstr = '0, ePc = '0;
    logic [5:0]  eWfid = '0;

    initial begin
        @(posedge clk);
        forever begin
            int          g;
            logic [N-1:0] expGrant;
            @(negedge clk);
            g = -1;
            if (!rst) begin
                if (mPhase == 0 && !issue_stall) begin
                    for (int k = N - 1; k >= 0; k--)
                        if (req_valid[(mPtr + k) % N]) g = (mPtr + k) % N;
                end else if (mPhase == 2 && req_valid[mIdx]) begin
                    g = mIdx;
                end
            end
            expGrant = '0;
            if (g >= 0) expGrant[g] = 1'b1;
            checkOutput("grant", 32'(grant), 32'(expGrant));
            checkOutput("wave_instr_valid", 32'(wave_instr_valid), 32'(eValid));
            checkOutput("wave_instr", wave_instr, eInstr);
            checkOutput("wave_instr_pc", wave_instr_pc, ePc);
            checkOutput("wave_wfid", 32'(wave_wfid), 32'(eWfid));
            checkOutput("err_half_mismatch", 32'(err_half_mismatch), 32'(eErrM));
            checkOutput("err_half_timeout", 32'(err_half_timeout), 32'(eErrT));

            if (rst) begin
                mPhase = 0; mPtr = 0; mIdx = 0; mWait = 0; mWfid = '0;
                eValid = 0; eErrM = 0; eErrT = 0; eInstr = '0; ePc = '0; eWfid = '0;
            end else begin
                eErrM  = 1'b0;
                eErrT  = 1'b0;
                eValid = (g >= 0);
                if (g >= 0) begin
                    eInstr = req_instr[32*g +: 32];
                    ePc    = req_pc[32*g +: 32];
                    eWfid  = req_wfid[6*g +: 6];
                end
                case (mPhase)
                    0: if (g >= 0) begin
                        mIdx = g; mWfid = req_wfid[6*g +: 6]; mPtr = (g + 1) % N; mPhase = 1;
                    end
                    1: begin
                        if (half_rqd && half_wfid == mWfid) begin mPhase = 2; mWait = 0; end
                        else begin eErrM = half_rqd; mPhase = 0; end
                    end
                    default: begin
                        if (g >= 0) mPhase = 0;
                        else begin
                            mWait++;
                            if (mWait == TO) begin eErrT = 1'b1; mPhase = 0; end
                        end
                    end
                endcase
            end
        end
    end

    // Global watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [N-1:0] expG;
        rst = 1'b1;
        req_instr = '0; req_pc = '0; req_wfid = '0;
        applyStimulus('0, 1'b0, 1'b0, 6'd0);
        for (int i = 0; i < N; i++) setPayload(i, 32'h1000_0000 + i, 32'h400 + 4*i, 6'(i + 1));
        waitCycle();
        waitCycle();
        applyStimulus(4'b1111, 1'b0, 1'b0, 6'd0);
        #2;
        checkOutput("reset_grant_zero", 32'(grant), 32'h0);
        checkOutput("reset_valid_zero", 32'(wave_instr_valid), 32'h0);
        checkOutput("reset_instr_zero", wave_instr, 32'h0);
        waitCycle();
        rst = 1'b0;

        // Single short instruction on requester 1.
        setPayload(1, 32'h7E00_0280, 32'h0000_0100, 6'd5);
        applyStimulus(4'b0010, 1'b0, 1'b0, 6'd0);
        #2 checkOutput("short_grant_t", 32'(grant), 32'h2);
        waitCycle();
        applyStimulus(4'b0010, 1'b0, 1'b0, 6'd0);
        #2;
        checkOutput("short_grant_t1", 32'(grant), 32'h0);
        checkOutput("short_valid_t1", 32'(wave_instr_valid), 32'h1);
        checkOutput("short_instr_t1", wave_instr, 32'h7E00_0280);
        checkOutput("short_wfid_t1", 32'(wave_wfid), 32'd5);
        waitCycle();
        applyStimulus(4'b0001, 1'b0, 1'b0, 6'd0);
        #2;
        checkOutput("short_valid_t2", 32'(wave_instr_valid), 32'h0);
        checkOutput("short_idle_t2", 32'(grant), 32'h1);
        waitCycle();
        applyStimulus('0, 1'b0, 1'b0, 6'd0);
        waitCycle();

        // Round-robin with all requesters continuously valid from reset.
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b1111, 1'b0, 1'b0, 6'd0);
            expG = '0;
            if (k % 2 == 0) expG[(k / 2) % N] = 1'b1;
            #2 checkOutput($sformatf("rr_grant_%0d", k), 32'(grant), 32'(expG));
            waitCycle();
        end
        applyStimulus('0, 1'b0, 1'b0, 6'd0);
        waitCycle();

        // Long instruction on requester 2.
        rst = 1'b1;
        waitCycle();
        rst = 1'b0;
        setPayload(2, 32'hD200_0000, 32'h0000_0200, 6'd9);
        applyStimulus(4'b0100, 1'b0, 1'b0, 6'd0);
        #2 checkOutput("long_grant_t", 32'(grant), 32'h4);
        waitCycle();
        setPayload(2, 32'h3F80_0000, 32'h0000_0204, 6'd9);
        applyStimulus(4'b0100, 1'b0, 1'b1, 6'd9);
        #2;
        checkOutput("long_check_nogrant", 32'(grant), 32'h0);
        checkOutput("long_first_instr", wave_instr, 32'hD200_0000);
        waitCycle();
        applyStimulus(4'b0100, 1'b1, 1'b0, 6'd0);
        #2 checkOutput("long_grant_t2", 32'(grant), 32'h4);
        waitCycle();
        applyStimulus(4'b1111, 1'b0, 1'b0, 6'd0);
        #2;
        checkOutput("long_second_valid", 32'(wave_instr_valid), 32'h1);
        checkOutput("long_second_instr", wave_instr, 32'h3F80_0000);
        checkOutput("long_ptr_after", 32'(grant), 32'h8);
        waitCycle();
        applyStimulus('0, 1'b0, 1'b0, 6'd0);
        waitCycle();

        // Half-dword wfid mismatch.
        setPayload(2, 32'hD200_0000, 32'h0000_0300, 6'd9);
        applyStimulus(4'b0100, 1'b0, 1'b0, 6'd0);
        #2 checkOutput("mis_grant_t", 32'(grant), 32'h4);
        waitCycle();
        applyStimulus(4'b0100, 1'b0, 1'b1, 6'd3);
        waitCycle();
        applyStimulus(4'b0100, 1'b1, 1'b0, 6'd0);
        #2;
        checkOutput("mis_err_pulse", 32'(err_half_mismatch), 32'h1);
        checkOutput("mis_no_second_grant", 32'(grant), 32'h0);
        waitCycle();
        #2 checkOutput("mis_err_clears", 32'(err_half_mismatch), 32'h0);
        waitCycle();
        applyStimulus('0, 1'b0, 1'b0, 6'd0);
        waitCycle();

        // Half-dword timeout while issue_stall holds.
        setPayload(0, 32'hC000_0001, 32'h0000_0500, 6'd7);
        applyStimulus(4'b0001, 1'b0, 1'b0, 6'd0);
        #2 checkOutput("to_grant_t", 32'(grant), 32'h1);
        waitCycle();
        applyStimulus(4'b1110, 1'b1, 1'b1, 6'd7);
        waitCycle();
        applyStimulus(4'b1110, 1'b1, 1'b0, 6'd0);
        for (int c = 0; c < TO; c++) begin
            #2 checkOutput($sformatf("to_wait_nogrant_%0d", c), 32'(grant), 32'h0);
            if (c == TO - 1)
                checkOutput("to_not_early", 32'(err_half_timeout), 32'h0);
            waitCycle();
        end
        #2;
        checkOutput("to_err_pulse", 32'(err_half_timeout), 32'h1);
        checkOutput("to_stall_nogrant", 32'(grant), 32'h0);
        waitCycle();
        #2 checkOutput("to_err_clears", 32'(err_half_timeout), 32'h0);
        waitCycle();
        applyStimulus(4'b1110, 1'b0, 1'b0, 6'd0);
        #2 checkOutput("to_resume_grant", 32'(grant), 32'h2);
        waitCycle();
        applyStimulus('0, 1'b0, 1'b0, 6'd0);
        waitCycle();

        // Reset while waiting in the half-dword phase.
        applyStimulus(4'b0100, 1'b0, 1'b0, 6'd0);
        #2 checkOutput("rsthalf_grant_t", 32'(grant), 32'h4);
        waitCycle();
        applyStimulus('0, 1'b0, 1'b1, 6'd9);
        waitCycle();
        applyStimulus('0, 1'b0, 1'b0, 6'd0);
        waitCycle();
        rst = 1'b1;
        applyStimulus(4'b0100, 1'b0, 1'b0, 6'd0);
        #2 checkOutput("rsthalf_grant_in_rst", 32'(grant), 32'h0);
        waitCycle();
        rst = 1'b0;
        applyStimulus(4'b1111, 1'b0, 1'b0, 6'd0);
        #2;
        checkOutput("rsthalf_valid", 32'(wave_instr_valid), 32'h0);
        checkOutput("rsthalf_instr", wave_instr, 32'h0);
        checkOutput("rsthalf_pc", wave_instr_pc, 32'h0);
        checkOutput("rsthalf_wfid", 32'(wave_wfid), 32'h0);
        checkOutput("rsthalf_errs", 32'({err_half_mismatch, err_half_timeout}), 32'h0);
        checkOutput("rsthalf_grant_req0", 32'(grant), 32'h1);
        waitCycle();
        applyStimulus('0, 1'b0, 1'b0, 6'd0);
        waitCycle();
        waitCycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
